// File: rtl/ext_int_source.sv
// ext_int_source
//   Memory-mapped external interrupt generator sitting on the CPU data bus.
//   After a programmable number of cycles it raises `interrupt` and holds it
//   until the CPU acknowledges with a full-word access to ACK_ADDR. It can give
//   up after ACK_TIMEOUT cycles, which sets a sticky TIMEOUT flag. It also
//   counts accepted acks. It can run one-shot or periodic.
//
// Ports
//   clk        in   rising-edge system clock
//   reset      in   asynchronous, active-high reset
//   addr       in   [31:0] data-bus byte address
//   byteen     in   [3:0]  data-bus byte enables (4'b1111 = full word)
//   wdata      in   [31:0] data-bus write data
//   rdata      out  [31:0] register read data, combinational from addr
//   interrupt  out  registered interrupt request (high while in ASSERT)
//
// Register map (offsets from BASE_ADDR)
//   +0x0 CTRL    RW     [0] EN, [1] PERIODIC
//   +0x4 PERIOD  RW     cycle count, 0 behaves as 1
//   +0x8 STATUS  R/W1C  [1:0] state, [2] TIMEOUT (write 1 to clear)
//   +0xC ACKCNT  RO     accepted-ack count, wraps

module ext_int_source #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_7F30,
   parameter logic [31:0] ACK_ADDR    = 32'h0000_7F20,
   parameter int          ACK_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        interrupt
);

   localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_COUNT  = 2'd1,
      S_ASSERT = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   cnt_q, cnt_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          en_q, en_d;
   logic          per_q, per_d;
   logic [31:0]   period_q, period_d;
   logic          timeout_q, timeout_d;
   logic [31:0]   ackcnt_q, ackcnt_d;
   logic          int_q;

   logic          hit, wr, ack;
   logic [31:0]   reload;

   // Base is 16-byte aligned, so the 4-word window is decoded on addr[31:4].
   assign hit    = (addr[31:4] == BASE_ADDR[31:4]);
   assign wr     = hit && (byteen == 4'b1111);
   assign ack    = (addr == ACK_ADDR) && (byteen == 4'b1111);
   // PERIOD of 0 counts like 1: both load 0 and assert on the following edge.
   assign reload = (period_q == 32'd0) ? 32'd0 : period_q - 32'd1;

   always_comb begin
      rdata = '0;
      if (hit) begin
         case (addr[3:2])
            2'd0: rdata = {30'd0, per_q, en_q};
            2'd1: rdata = period_q;
            2'd2: rdata = {29'd0, timeout_q, state_q};
            default: rdata = ackcnt_q;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tmr_d     = tmr_q;
      en_d      = en_q;
      per_d     = per_q;
      period_d  = period_q;
      timeout_d = timeout_q;
      ackcnt_d  = ackcnt_q;

      case (state_q)
         S_IDLE: begin
            if (en_q) begin
               state_d = S_COUNT;
               cnt_d   = reload;
            end
         end
         S_COUNT: begin
            if (!en_q) begin
               state_d = S_IDLE;
            end else if (cnt_q == 32'd0) begin
               state_d = S_ASSERT;
               tmr_d   = '0;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         S_ASSERT: begin
            // Clearing EN here does not withdraw a request already raised.
            if (ack) begin
               state_d  = S_DONE;
               ackcnt_d = ackcnt_q + 32'd1;
            end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: begin
            if (per_q && en_q) begin
               state_d = S_COUNT;
               cnt_d   = reload;
            end else begin
               state_d = S_IDLE;
               if (!per_q) en_d = 1'b0;
            end
         end
      endcase

      // Bus writes come last so they override the hardware one-shot EN clear.
      if (wr) begin
         case (addr[3:2])
            2'd0: begin
               en_d  = wdata[0];
               per_d = wdata[1];
            end
            2'd1: period_d = wdata;
            2'd2: if (wdata[2]) timeout_d = 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         tmr_q     <= '0;
         en_q      <= 1'b0;
         per_q     <= 1'b0;
         period_q  <= '0;
         timeout_q <= 1'b0;
         ackcnt_q  <= '0;
         int_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
         en_q      <= en_d;
         per_q     <= per_d;
         period_q  <= period_d;
         timeout_q <= timeout_d;
         ackcnt_q  <= ackcnt_d;
         int_q     <= (state_d == S_ASSERT);
      end
   end

   assign interrupt = int_q;

endmodule

// File: tb/tb_ext_int_source.sv
module tb_ext_int_source;

   localparam logic [31:0] A_CTRL = 32'h0000_7F30;
   localparam logic [31:0] A_PER  = 32'h0000_7F34;
   localparam logic [31:0] A_STAT = 32'h0000_7F38;
   localparam logic [31:0] A_ACNT = 32'h0000_7F3C;
   localparam logic [31:0] A_ACK  = 32'h0000_7F20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] addr = '0;
   logic [3:0]  byteen = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        interrupt;

   int nchk = 0;
   int nerr = 0;

   ext_int_source #(
      .BASE_ADDR  (32'h0000_7F30),
      .ACK_ADDR   (32'h0000_7F20),
      .ACK_TIMEOUT(8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .byteen   (byteen),
      .wdata    (wdata),
      .rdata    (rdata),
      .interrupt(interrupt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_int;
   } vec_t;

   vec_t tbl[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr = a; byteen = 4'b1111; wdata = d;
      tick();
      addr = '0; byteen = '0; wdata = '0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      addr = a; byteen = '0;
      #1;
      v = rdata;
      addr = '0;
   endtask

   task automatic do_ack();
      addr = A_ACK; byteen = 4'b1111;
      tick();
      addr = '0; byteen = '0;
   endtask

   // Edges counted from now until interrupt is seen high; 50 means it never rose.
   task automatic wait_rise(output int n);
      n = 0;
      while (!interrupt && n < 50) begin
         tick();
         n++;
      end
   endtask

   logic [31:0] v;
   int n;

   initial begin
      tbl[0]  = '{A_CTRL, 4'h0, 32'h0, 32'h0, 1'b0};
      tbl[1]  = '{A_PER,  4'h0, 32'h0, 32'h0, 1'b0};
      tbl[2]  = '{A_STAT, 4'h0, 32'h0, 32'h0, 1'b0};
      tbl[3]  = '{A_ACNT, 4'h0, 32'h0, 32'h0, 1'b0};
      tbl[4]  = '{32'h0000_7F40, 4'h0, 32'h0, 32'h0, 1'b0};
      tbl[5]  = '{A_CTRL, 4'b0011, 32'h1, 32'h0, 1'b0};          // partial write
      tbl[6]  = '{A_CTRL, 4'h0, 32'h0, 32'h0, 1'b0};
      tbl[7]  = '{A_PER,  4'hF, 32'h1234, 32'h0, 1'b0};
      tbl[8]  = '{A_PER,  4'h0, 32'h0, 32'h1234, 1'b0};
      tbl[9]  = '{32'h0000_7F40, 4'hF, 32'h5, 32'h0, 1'b0};     // out of window
      tbl[10] = '{A_CTRL, 4'h0, 32'h0, 32'h0, 1'b0};
      tbl[11] = '{A_PER,  4'b1110, 32'h7, 32'h1234, 1'b0};
      tbl[12] = '{A_PER,  4'h0, 32'h0, 32'h1234, 1'b0};
      tbl[13] = '{A_CTRL, 4'hF, 32'hFFFF_FFFE, 32'h0, 1'b0};    // PERIODIC only
      tbl[14] = '{A_CTRL, 4'h0, 32'h0, 32'h2, 1'b0};
      tbl[15] = '{A_CTRL, 4'hF, 32'h0, 32'h2, 1'b0};
      tbl[16] = '{A_STAT, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0};
      tbl[17] = '{A_ACNT, 4'hF, 32'hFFFF, 32'h0, 1'b0};         // read-only
      tbl[18] = '{A_ACNT, 4'h0, 32'h0, 32'h0, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset interrupt", {31'd0, interrupt}, 32'd0);
      reset = 1'b0;
      tick();

      // Register access vectors: read value is checked before the edge.
      for (int i = 0; i < 19; i++) begin
         addr = tbl[i].a; byteen = tbl[i].be; wdata = tbl[i].wd;
         #1;
         chk($sformatf("vec%0d rdata", i), rdata, tbl[i].exp_rd);
         chk($sformatf("vec%0d int", i), {31'd0, interrupt}, {31'd0, tbl[i].exp_int});
         tick();
      end
      addr = '0; byteen = '0; wdata = '0;

      // One-shot
      wr(A_PER, 32'd5);
      wr(A_CTRL, 32'd1);
      wait_rise(n);
      chk("oneshot rise edges", n, 32'd6);
      rd(A_STAT, v); chk("oneshot status assert", v, 32'd2);
      do_ack();
      chk("oneshot fall", {31'd0, interrupt}, 32'd0);
      rd(A_STAT, v); chk("oneshot status done", v, 32'd3);
      tick();
      rd(A_CTRL, v); chk("oneshot ctrl cleared", v, 32'd0);
      rd(A_STAT, v); chk("oneshot status idle", v, 32'd0);
      rd(A_ACNT, v); chk("oneshot ackcnt", v, 32'd1);

      // False ack with partial byte enables
      wr(A_PER, 32'd1);
      wr(A_CTRL, 32'd1);
      wait_rise(n);
      chk("falseack rise edges", n, 32'd2);
      addr = A_ACK; byteen = 4'b0001;
      tick(); tick();
      chk("falseack ignored", {31'd0, interrupt}, 32'd1);
      do_ack();
      chk("falseack real ack", {31'd0, interrupt}, 32'd0);
      tick();
      rd(A_CTRL, v); chk("falseack ctrl", v, 32'd0);

      // Periodic: each rise 4 edges after the enabling write or the ack
      wr(A_PER, 32'd3);
      wr(A_CTRL, 32'd3);
      for (int k = 0; k < 3; k++) begin
         wait_rise(n);
         chk($sformatf("periodic rise%0d edges", k), n, 32'd4);
         tick(); tick();
         chk($sformatf("periodic held%0d", k), {31'd0, interrupt}, 32'd1);
         do_ack();
         chk($sformatf("periodic fall%0d", k), {31'd0, interrupt}, 32'd0);
      end
      wr(A_CTRL, 32'd0);                 // lands on the DONE->COUNT edge
      repeat (8) tick();
      chk("periodic stop int", {31'd0, interrupt}, 32'd0);
      rd(A_STAT, v); chk("periodic stop status", v, 32'd0);
      rd(A_ACNT, v); chk("periodic ackcnt", v, 32'd5);

      // Timeout after 8 cycles high
      wr(A_PER, 32'd1);
      wr(A_CTRL, 32'd1);
      wait_rise(n);
      n = 0;
      while (interrupt && n < 20) begin
         n++;
         tick();
      end
      chk("timeout high cycles", n, 32'd8);
      rd(A_STAT, v); chk("timeout status done", v, 32'd7);
      tick();
      rd(A_STAT, v); chk("timeout status idle", v, 32'd4);
      wr(A_STAT, 32'd4);
      rd(A_STAT, v); chk("timeout w1c", v, 32'd0);
      rd(A_ACNT, v); chk("timeout ackcnt", v, 32'd5);

      // Disable during COUNT
      wr(A_PER, 32'd100);
      wr(A_CTRL, 32'd1);
      repeat (10) tick();
      rd(A_STAT, v); chk("disable status count", v, 32'd1);
      wr(A_CTRL, 32'd0);
      repeat (5) tick();
      chk("disable no int", {31'd0, interrupt}, 32'd0);
      rd(A_STAT, v); chk("disable status idle", v, 32'd0);

      // Disable during ASSERT: request stays until acked
      wr(A_PER, 32'd2);
      wr(A_CTRL, 32'd1);
      wait_rise(n);
      chk("disassert rise edges", n, 32'd3);
      wr(A_CTRL, 32'd0);
      repeat (3) tick();
      chk("disassert held", {31'd0, interrupt}, 32'd1);
      do_ack();
      chk("disassert fall", {31'd0, interrupt}, 32'd0);
      rd(A_ACNT, v); chk("disassert ackcnt", v, 32'd6);

      // PERIOD=0 acts as 1, then async reset mid-ASSERT
      wr(A_PER, 32'd0);
      wr(A_CTRL, 32'd3);
      wait_rise(n);
      chk("period0 rise edges", n, 32'd2);
      #2;
      reset = 1'b1;
      #1;
      chk("async reset int", {31'd0, interrupt}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      rd(A_CTRL, v); chk("post reset ctrl", v, 32'd0);
      rd(A_PER,  v); chk("post reset period", v, 32'd0);
      rd(A_STAT, v); chk("post reset status", v, 32'd0);
      rd(A_ACNT, v); chk("post reset ackcnt", v, 32'd0);
      repeat (4) tick();
      chk("post reset idle int", {31'd0, interrupt}, 32'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
